store_queue: RTL and testbench

Circular store queue between dispatch, the load/store functional unit and the data cache. Allocates one entry per dispatched store and hands out its slot index. Fills the entry's address and data when the LS unit resolves it. Resolves each load against all older stores as forward, stall or go-to-memory, and drains ROB-committed stores to the D-cache in program order.

---
 rtl/store_queue_if.sv | 63 ++++++
 rtl/store_queue.sv | 173 +++++++++++++++++
 tb/tb_store_queue.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/store_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_queue_if : dispatch / LS unit / ROB / D-cache bundle for the store  |
// | queue.                                                                    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface store_queue_if #(
    parameter int SQ_SIZE = 8,
    parameter int XLEN    = 32
);
    localparam int LSQ_IDX_LEN = $clog2(SQ_SIZE);

    logic                   squash;
    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [LSQ_IDX_LEN-1:0] alloc_pos;

    logic                   fu_valid;
    logic                   fu_store;
    logic [LSQ_IDX_LEN-1:0] fu_sq_pos;
    logic [XLEN-1:0]        fu_addr;
    logic [XLEN-1:0]        fu_value;
    logic [1:0]             fu_mem_size;

    logic                   ld_valid;
    logic [XLEN-1:0]        ld_addr;
    logic [1:0]             ld_mem_size;
    logic [LSQ_IDX_LEN-1:0] ld_sq_pos;
    logic                   ld_forward;
    logic                   ld_stall;
    logic [XLEN-1:0]        ld_value;

    logic                   commit_valid;

    logic                   mem_req_valid;
    logic [XLEN-1:0]        mem_req_addr;
    logic [XLEN-1:0]        mem_req_data;
    logic [1:0]             mem_req_size;
    logic                   mem_req_ack;

    modport master (
        output squash, alloc_valid,
        input  alloc_ready, alloc_pos,
        output fu_valid, fu_store, fu_sq_pos, fu_addr, fu_value, fu_mem_size,
        output ld_valid, ld_addr, ld_mem_size, ld_sq_pos,
        input  ld_forward, ld_stall, ld_value,
        output commit_valid,
        input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_size,
        output mem_req_ack
    );

    modport slave (
        input  squash, alloc_valid,
        output alloc_ready, alloc_pos,
        input  fu_valid, fu_store, fu_sq_pos, fu_addr, fu_value, fu_mem_size,
        input  ld_valid, ld_addr, ld_mem_size, ld_sq_pos,
        output ld_forward, ld_stall, ld_value,
        input  commit_valid,
        output mem_req_valid, mem_req_addr, mem_req_data, mem_req_size,
        input  mem_req_ack
    );
endinterface
`default_nettype wire

// File: rtl/store_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_queue : circular store queue with store-to-load forwarding and      |
// | in-order drain of committed stores to the D-cache.                        |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module store_queue #(
    parameter int SQ_SIZE = 8,
    parameter int XLEN    = 32
) (
    input  wire logic    clock,
    input  wire logic    reset,
    store_queue_if.slave sq
);
    localparam int LSQ_IDX_LEN = $clog2(SQ_SIZE);

    typedef logic [LSQ_IDX_LEN-1:0] idx_t;
    typedef logic [LSQ_IDX_LEN:0]   cnt_t;

    localparam cnt_t C_FULL = cnt_t'(SQ_SIZE);

    // Entry storage
    logic [SQ_SIZE-1:0] valid_q;
    logic [SQ_SIZE-1:0] addr_valid_q;
    logic [SQ_SIZE-1:0] committed_q;
    logic [XLEN-1:0]    addr_q [SQ_SIZE];
    logic [XLEN-1:0]    data_q [SQ_SIZE];
    logic [1:0]         size_q [SQ_SIZE];

    idx_t head_q, head_d;
    idx_t tail_q, tail_d;
    cnt_t count_q, count_d;
    cnt_t commit_cnt_q, commit_cnt_d;

    logic alloc_fire;
    logic fill_fire;
    logic commit_fire;
    logic ack_fire;
    idx_t commit_slot;

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << a;
            2'd1:    m = 4'b0011 << a;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    always_comb begin
        alloc_fire  = sq.alloc_valid && (count_q < C_FULL) && !sq.squash;
        fill_fire   = sq.fu_valid && sq.fu_store && valid_q[sq.fu_sq_pos];
        commit_fire = sq.commit_valid && (commit_cnt_q < count_q);
        ack_fire    = committed_q[head_q] && sq.mem_req_ack;
        commit_slot = head_q + idx_t'(commit_cnt_q);

        head_d       = head_q + idx_t'(ack_fire);
        commit_cnt_d = commit_cnt_q + cnt_t'(commit_fire) - cnt_t'(ack_fire);

        // Squash keeps everything committed, including this cycle's commit.
        if (sq.squash) begin
            tail_d  = head_q + idx_t'(commit_cnt_q + cnt_t'(commit_fire));
            count_d = commit_cnt_d;
        end else begin
            tail_d  = tail_q + idx_t'(alloc_fire);
            count_d = count_q + cnt_t'(alloc_fire) - cnt_t'(ack_fire);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= '0;
            addr_valid_q <= '0;
            committed_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            commit_cnt_q <= '0;
            for (int i = 0; i < SQ_SIZE; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                size_q[i] <= '0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            commit_cnt_q <= commit_cnt_d;
            for (int i = 0; i < SQ_SIZE; i++) begin
                if (fill_fire && (sq.fu_sq_pos == idx_t'(i))) begin
                    addr_q[i]       <= sq.fu_addr;
                    data_q[i]       <= sq.fu_value;
                    size_q[i]       <= sq.fu_mem_size;
                    addr_valid_q[i] <= 1'b1;
                end
                if (commit_fire && (commit_slot == idx_t'(i))) begin
                    committed_q[i] <= 1'b1;
                end
                if (alloc_fire && (tail_q == idx_t'(i))) begin
                    valid_q[i]      <= 1'b1;
                    addr_valid_q[i] <= 1'b0;
                    committed_q[i]  <= 1'b0;
                    addr_q[i]       <= '0;
                    data_q[i]       <= '0;
                    size_q[i]       <= '0;
                end
                if (ack_fire && (head_q == idx_t'(i))) begin
                    valid_q[i]      <= 1'b0;
                    addr_valid_q[i] <= 1'b0;
                    committed_q[i]  <= 1'b0;
                end
                if (sq.squash && valid_q[i] && !committed_q[i] &&
                    !(commit_fire && (commit_slot == idx_t'(i)))) begin
                    valid_q[i]      <= 1'b0;
                    addr_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Load lookup: scan oldest to youngest so the last hit is the youngest.
    idx_t            older_cnt;
    idx_t            slot;
    idx_t            hit_slot;
    logic            hit;
    logic            any_unres;
    logic            covers;
    logic [3:0]      ld_mask;
    logic [3:0]      st_mask;
    logic [XLEN-1:0] shifted;
    logic            fwd;
    logic            stall;

    always_comb begin
        ld_mask   = byte_mask(sq.ld_mem_size, sq.ld_addr[1:0]);
        older_cnt = sq.ld_sq_pos - head_q;
        any_unres = 1'b0;
        hit       = 1'b0;
        hit_slot  = '0;
        slot      = '0;
        for (int k = 0; k < SQ_SIZE; k++) begin
            slot = head_q + idx_t'(k);
            if ((idx_t'(k) < older_cnt) && valid_q[slot]) begin
                if (!addr_valid_q[slot]) begin
                    any_unres = 1'b1;
                end else if ((addr_q[slot][XLEN-1:2] == sq.ld_addr[XLEN-1:2]) &&
                             ((byte_mask(size_q[slot], addr_q[slot][1:0]) & ld_mask) != 4'b0000)) begin
                    hit      = 1'b1;
                    hit_slot = slot;
                end
            end
        end
        st_mask = byte_mask(size_q[hit_slot], addr_q[hit_slot][1:0]);
        covers  = ((st_mask & ld_mask) == ld_mask);
        shifted = (data_q[hit_slot] << {addr_q[hit_slot][1:0], 3'b000}) >> {sq.ld_addr[1:0], 3'b000};
        stall   = sq.ld_valid && (any_unres || (hit && !covers));
        fwd     = sq.ld_valid && !any_unres && hit && covers;
    end

    assign sq.ld_forward    = fwd;
    assign sq.ld_stall      = stall;
    assign sq.ld_value      = fwd ? shifted : '0;

    assign sq.alloc_ready   = (count_q < C_FULL);
    assign sq.alloc_pos     = tail_q;

    assign sq.mem_req_valid = committed_q[head_q];
    assign sq.mem_req_addr  = addr_q[head_q];
    assign sq.mem_req_data  = data_q[head_q];
    assign sq.mem_req_size  = size_q[head_q];
endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_store_queue : directed vector bench for store_queue.                   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_store_queue;
    localparam int SQ_SIZE = 8;
    localparam int XLEN    = 32;
    localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2;

    logic clock = 1'b0;
    logic reset;

    store_queue_if #(.SQ_SIZE(SQ_SIZE), .XLEN(XLEN)) sq ();
    store_queue #(.SQ_SIZE(SQ_SIZE), .XLEN(XLEN)) dut (.clock(clock), .reset(reset), .sq(sq));

    always #5 clock = ~clock;

    typedef struct packed {
        logic        rst;
        logic        alloc;
        logic        commit;
        logic        ack;
        logic        squash;
        logic        fu_v;
        logic [2:0]  fu_pos;
        logic [31:0] fu_addr;
        logic [31:0] fu_val;
        logic [1:0]  fu_size;
        logic        ld_v;
        logic [31:0] ld_addr;
        logic [1:0]  ld_size;
        logic [2:0]  ld_pos;
        logic        rdy;
        logic [2:0]  pos;
        logic        fwd;
        logic        stall;
        logic [31:0] val;
        logic        mv;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [1:0]  msize;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Commit-order model used only to catch commits of unresolved stores.
    logic [SQ_SIZE-1:0] m_filled;
    logic [2:0]         m_cpos;

    always @(posedge clock) begin
        if (reset) begin
            m_filled <= '0;
            m_cpos   <= '0;
        end else begin
            if (sq.commit_valid) begin
                assert (m_filled[m_cpos]) else $error("FAIL commit_unresolved slot %0d", m_cpos);
                m_cpos <= m_cpos + 3'd1;
            end
            if (sq.fu_valid && sq.fu_store) m_filled[sq.fu_sq_pos] <= 1'b1;
            if (sq.alloc_valid && sq.alloc_ready && !sq.squash) m_filled[sq.alloc_pos] <= 1'b0;
        end
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset           = v.rst;
        sq.alloc_valid  = v.alloc;
        sq.commit_valid = v.commit;
        sq.mem_req_ack  = v.ack;
        sq.squash       = v.squash;
        sq.fu_valid     = v.fu_v;
        sq.fu_store     = v.fu_v;
        sq.fu_sq_pos    = v.fu_pos;
        sq.fu_addr      = v.fu_addr;
        sq.fu_value     = v.fu_val;
        sq.fu_mem_size  = v.fu_size;
        sq.ld_valid     = v.ld_v;
        sq.ld_addr      = v.ld_addr;
        sq.ld_mem_size  = v.ld_size;
        sq.ld_sq_pos    = v.ld_pos;
    endtask

    initial begin
        vec_t v;
        vec_t idle;
        int   lat;

        idle = '0;
        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_alloc_ready", -1, 32'(sq.alloc_ready), 32'd1);
        chk("reset_alloc_pos",   -1, 32'(sq.alloc_pos),   32'd0);
        chk("reset_mem_valid",   -1, 32'(sq.mem_req_valid), 32'd0);
        chk("reset_mem_addr",    -1, sq.mem_req_addr, 32'd0);
        chk("reset_mem_data",    -1, sq.mem_req_data, 32'd0);
        chk("reset_ld_value",    -1, sq.ld_value, 32'd0);

        // Fill to capacity; ninth alloc refused, tail stays 0.
        for (int i = 0; i < 8; i++) tbl.push_back(vec_t'{alloc:1'b1, rdy:1'b1, pos:3'(i), default:'0});
        tbl.push_back(vec_t'{alloc:1'b1, default:'0});
        tbl.push_back(vec_t'{default:'0});
        // Fills and lookups; fill-cycle lookup still sees the entry unresolved.
        tbl.push_back(vec_t'{fu_v:1'b1, fu_pos:3'd0, fu_addr:32'h300, fu_val:32'h11111111, fu_size:W,
                             ld_v:1'b1, ld_addr:32'h300, ld_size:W, ld_pos:3'd1, stall:1'b1, default:'0});
        tbl.push_back(vec_t'{fu_v:1'b1, fu_pos:3'd2, fu_addr:32'h100, fu_val:32'hDEADBEEF, fu_size:W,
                             ld_v:1'b1, ld_addr:32'h300, ld_size:W, ld_pos:3'd1, fwd:1'b1, val:32'h11111111, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h102, ld_size:H, ld_pos:3'd3, stall:1'b1, default:'0});
        tbl.push_back(vec_t'{fu_v:1'b1, fu_pos:3'd1, fu_addr:32'h200, fu_val:32'h22222222, fu_size:W,
                             ld_v:1'b1, ld_addr:32'h102, ld_size:H, ld_pos:3'd3, stall:1'b1, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h102, ld_size:H, ld_pos:3'd3, fwd:1'b1, val:32'h0000DEAD, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h103, ld_size:B, ld_pos:3'd3, fwd:1'b1, val:32'h000000DE, default:'0});
        tbl.push_back(vec_t'{fu_v:1'b1, fu_pos:3'd3, fu_addr:32'h400, fu_val:32'h000000AA, fu_size:B, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h400, ld_size:W, ld_pos:3'd4, stall:1'b1, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h401, ld_size:B, ld_pos:3'd4, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h400, ld_size:B, ld_pos:3'd4, fwd:1'b1, val:32'h000000AA, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h100, ld_size:W, ld_pos:3'd0, default:'0});
        tbl.push_back(vec_t'{fu_v:1'b1, fu_pos:3'd4, fu_addr:32'h102, fu_val:32'h00001234, fu_size:H, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h102, ld_size:H, ld_pos:3'd5, fwd:1'b1, val:32'h00001234, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h100, ld_size:W, ld_pos:3'd5, stall:1'b1, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h100, ld_size:H, ld_pos:3'd5, fwd:1'b1, val:32'hDEADBEEF, default:'0});
        // Drain from a full queue; alloc+ack while full is refused, next alloc wraps.
        tbl.push_back(vec_t'{commit:1'b1, default:'0});
        tbl.push_back(vec_t'{mv:1'b1, maddr:32'h300, mdata:32'h11111111, msize:W, default:'0});
        tbl.push_back(vec_t'{mv:1'b1, maddr:32'h300, mdata:32'h11111111, msize:W, default:'0});
        tbl.push_back(vec_t'{alloc:1'b1, ack:1'b1, mv:1'b1, maddr:32'h300, mdata:32'h11111111, msize:W, default:'0});
        tbl.push_back(vec_t'{alloc:1'b1, rdy:1'b1, pos:3'd0, default:'0});
        tbl.push_back(vec_t'{commit:1'b1, pos:3'd1, default:'0});
        // Reset while a drain request is pending.
        tbl.push_back(vec_t'{rst:1'b1, pos:3'd1, mv:1'b1, maddr:32'h200, mdata:32'h22222222, msize:W, default:'0});
        tbl.push_back(vec_t'{rdy:1'b1, pos:3'd0, default:'0});
        // Four stores, commit two, squash (with a dropped alloc), then drain.
        for (int i = 0; i < 4; i++) tbl.push_back(vec_t'{alloc:1'b1, rdy:1'b1, pos:3'(i), default:'0});
        tbl.push_back(vec_t'{fu_v:1'b1, fu_pos:3'd0, fu_addr:32'h500, fu_val:32'hA0A0A0A0, fu_size:W, rdy:1'b1, pos:3'd4, default:'0});
        tbl.push_back(vec_t'{fu_v:1'b1, fu_pos:3'd1, fu_addr:32'h504, fu_val:32'hB1B1B1B1, fu_size:W, rdy:1'b1, pos:3'd4, default:'0});
        tbl.push_back(vec_t'{commit:1'b1, rdy:1'b1, pos:3'd4, default:'0});
        tbl.push_back(vec_t'{commit:1'b1, squash:1'b1, alloc:1'b1, rdy:1'b1, pos:3'd4,
                             mv:1'b1, maddr:32'h500, mdata:32'hA0A0A0A0, msize:W, default:'0});
        tbl.push_back(vec_t'{ack:1'b1, rdy:1'b1, pos:3'd2, mv:1'b1, maddr:32'h500, mdata:32'hA0A0A0A0, msize:W, default:'0});
        tbl.push_back(vec_t'{ack:1'b1, rdy:1'b1, pos:3'd2, mv:1'b1, maddr:32'h504, mdata:32'hB1B1B1B1, msize:W, default:'0});
        tbl.push_back(vec_t'{alloc:1'b1, rdy:1'b1, pos:3'd2, default:'0});
        tbl.push_back(vec_t'{alloc:1'b1, ack:1'b1, rdy:1'b1, pos:3'd3, default:'0});
        // Ack honored in a squash cycle; the uncommitted younger store disappears.
        tbl.push_back(vec_t'{fu_v:1'b1, fu_pos:3'd2, fu_addr:32'h600, fu_val:32'hC3C3C3C3, fu_size:W, rdy:1'b1, pos:3'd4, default:'0});
        tbl.push_back(vec_t'{commit:1'b1, rdy:1'b1, pos:3'd4, default:'0});
        tbl.push_back(vec_t'{ack:1'b1, squash:1'b1, rdy:1'b1, pos:3'd4,
                             mv:1'b1, maddr:32'h600, mdata:32'hC3C3C3C3, msize:W, default:'0});
        tbl.push_back(vec_t'{ld_v:1'b1, ld_addr:32'h600, ld_size:W, ld_pos:3'd4, rdy:1'b1, pos:3'd3, default:'0});

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clock);
            drive(v);
            #1;
            chk("alloc_ready",   i, 32'(sq.alloc_ready),   32'(v.rdy));
            chk("alloc_pos",     i, 32'(sq.alloc_pos),     32'(v.pos));
            chk("ld_forward",    i, 32'(sq.ld_forward),    32'(v.fwd));
            chk("ld_stall",      i, 32'(sq.ld_stall),      32'(v.stall));
            chk("mem_req_valid", i, 32'(sq.mem_req_valid), 32'(v.mv));
            if (v.fwd) chk("ld_value", i, sq.ld_value, v.val);
            if (v.mv) begin
                chk("mem_req_addr", i, sq.mem_req_addr, v.maddr);
                chk("mem_req_data", i, sq.mem_req_data, v.mdata);
                chk("mem_req_size", i, 32'(sq.mem_req_size), 32'(v.msize));
            end
        end

        // Drain latency: request appears the cycle after the commit edge.
        @(negedge clock);
        v = '0; v.alloc = 1'b1; drive(v);
        @(negedge clock);
        v = '0; v.fu_v = 1'b1; v.fu_pos = 3'd3; v.fu_addr = 32'h700; v.fu_val = 32'h12345678; v.fu_size = W; drive(v);
        @(negedge clock);
        v = '0; v.commit = 1'b1; drive(v);
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            drive(idle);
            #1;
            lat++;
            if (sq.mem_req_valid) break;
        end
        chk("drain_latency", 100, 32'(lat), 32'd1);
        chk("drain_addr",    100, sq.mem_req_addr, 32'h700);
        chk("drain_data",    100, sq.mem_req_data, 32'h12345678);
        sq.mem_req_ack = 1'b1;
        @(negedge clock);
        drive(idle);
        #1;
        chk("drained_valid", 101, 32'(sq.mem_req_valid), 32'd0);
        chk("drained_pos",   101, 32'(sq.alloc_pos),     32'd4);
        chk("drained_ready", 101, 32'(sq.alloc_ready),   32'd1);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
